// File: rtl/mainmem_pkg.sv
// Shared types and default widths for the main-memory controller.
package mainmem_pkg;

    typedef enum logic [1:0] {
        MM_IDLE,
        MM_WRBUSY,
        MM_WAIT,
        MM_DONE
    } mm_state_t;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 16;

endpackage

// File: rtl/mm_lat_counter.sv
// Down-counter that times the RAM read latency; loads RAM_LAT-1 and
// counts toward zero while enabled.
module mm_lat_counter #(
    parameter int RAM_LAT = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic zero
);

    localparam int CNT_W = $clog2(RAM_LAT) + 1;

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= CNT_W'(RAM_LAT - 1);
        end else if (en && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/mainmem_ctrl.sv
// Memory-stage responder: posts writes immediately and stalls the pipeline
// while a read waits out the fixed RAM latency.
module mainmem_ctrl
    import mainmem_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int RAM_AW  = 16,
    parameter int RAM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] main_mem_read_adr,
    input  logic [ADDR_W-1:0] main_mem_write_adr,
    input  logic [DATA_W-1:0] main_mem_write_dat,
    output logic [DATA_W-1:0] main_mem_read_dat,
    output logic              main_mem_waiting,
    output logic [RAM_AW-1:0] ram_adr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdat,
    input  logic [DATA_W-1:0] ram_rdat
);

    mm_state_t         state_reg;
    logic [RAM_AW-1:0] adr_q_reg;
    logic [DATA_W-1:0] read_dat_reg;
    logic              cnt_load;
    logic              cnt_en;
    logic              cnt_zero;

    mm_lat_counter #(
        .RAM_LAT (RAM_LAT)
    ) u_lat_counter (
        .clk   (clk),
        .reset (reset),
        .load  (cnt_load),
        .en    (cnt_en),
        .zero  (cnt_zero)
    );

    always_comb begin
        ram_we           = 1'b0;
        ram_adr          = main_mem_read_adr[RAM_AW-1:0];
        ram_wdat         = main_mem_write_dat;
        main_mem_waiting = 1'b0;
        cnt_load         = 1'b0;
        cnt_en           = 1'b0;
        case (state_reg)
            MM_IDLE: begin
                // A simultaneous write goes to the RAM first; the read follows from adr_q.
                if (mem_write) begin
                    ram_we           = 1'b1;
                    ram_adr          = main_mem_write_adr[RAM_AW-1:0];
                    main_mem_waiting = mem_read;
                end else if (mem_read) begin
                    main_mem_waiting = 1'b1;
                    cnt_load         = 1'b1;
                end
            end
            MM_WRBUSY: begin
                ram_adr          = adr_q_reg;
                main_mem_waiting = 1'b1;
                cnt_load         = 1'b1;
            end
            MM_WAIT: begin
                ram_adr          = adr_q_reg;
                main_mem_waiting = 1'b1;
                cnt_en           = 1'b1;
            end
            default: begin
            end
        endcase
        if (reset) begin
            ram_we           = 1'b0;
            main_mem_waiting = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= MM_IDLE;
            adr_q_reg    <= '0;
            read_dat_reg <= '0;
        end else begin
            case (state_reg)
                MM_IDLE: begin
                    if (mem_read) begin
                        adr_q_reg <= main_mem_read_adr[RAM_AW-1:0];
                        state_reg <= mem_write ? MM_WRBUSY : MM_WAIT;
                    end
                end
                MM_WRBUSY: state_reg <= MM_WAIT;
                MM_WAIT: begin
                    if (cnt_zero) begin
                        read_dat_reg <= ram_rdat;
                        state_reg    <= MM_DONE;
                    end
                end
                // Inputs still show the finished request here, so they are ignored.
                MM_DONE: state_reg <= MM_IDLE;
                default: state_reg <= MM_IDLE;
            endcase
        end
    end

    assign main_mem_read_dat = read_dat_reg;

endmodule

// File: tb/tb_mainmem_ctrl.sv
// Bench for mainmem_ctrl: three instances (RAM_LAT 2, 1, 4), each with its
// own RAM model; table-driven transactions plus reset and latency sequences.
module tb_mainmem_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] read_adr = '0;
    logic [15:0] write_adr = '0;
    logic [15:0] write_dat = '0;
    logic        pre_we = 1'b0;
    logic [15:0] pre_adr = '0;
    logic [15:0] pre_dat = '0;

    logic        mem_read_v  [3];
    logic        mem_write_v [3];
    logic [15:0] rdat_v      [3];
    logic        waiting_v   [3];
    logic [15:0] ram_adr_v   [3];
    logic        we_v        [3];
    logic [15:0] ram_wdat_v  [3];
    logic [15:0] ram_rdat_v  [3];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dut
            localparam int LAT = (gi == 0) ? 2 : ((gi == 1) ? 1 : 4);
            logic [15:0] mem  [65536];
            logic [15:0] pipe [LAT];

            mainmem_ctrl #(
                .DATA_W  (16),
                .ADDR_W  (16),
                .RAM_AW  (16),
                .RAM_LAT (LAT)
            ) u_dut (
                .clk                (clk),
                .reset              (reset),
                .mem_read           (mem_read_v[gi]),
                .mem_write          (mem_write_v[gi]),
                .main_mem_read_adr  (read_adr),
                .main_mem_write_adr (write_adr),
                .main_mem_write_dat (write_dat),
                .main_mem_read_dat  (rdat_v[gi]),
                .main_mem_waiting   (waiting_v[gi]),
                .ram_adr            (ram_adr_v[gi]),
                .ram_we             (we_v[gi]),
                .ram_wdat           (ram_wdat_v[gi]),
                .ram_rdat           (ram_rdat_v[gi])
            );

            // Synchronous RAM with LAT-cycle read pipeline.
            always @(posedge clk) begin
                if (pre_we) mem[pre_adr] <= pre_dat;
                else if (we_v[gi]) mem[ram_adr_v[gi]] <= ram_wdat_v[gi];
                pipe[0] <= mem[ram_adr_v[gi]];
                for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
            end
            assign ram_rdat_v[gi] = pipe[LAT-1];
        end
    endgenerate

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] radr;
        logic [15:0] wadr;
        logic [15:0] wdat;
        logic        exp_we;
        logic [15:0] exp_adr;
        int          exp_waits;
        logic [15:0] exp_rdat;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        @(posedge clk); #1;
        pre_we = 1'b1; pre_adr = a; pre_dat = d;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    // One request held until the stall ends, then dropped after DONE.
    task automatic do_txn(input int idx, input logic rd, input logic wr,
                          input logic [15:0] radr, input logic [15:0] wadr, input logic [15:0] wdat,
                          output logic first_we, output logic [15:0] first_adr, output logic [15:0] first_wdat,
                          output int waits, output logic [15:0] done_rdat, output logic done_wait,
                          output logic after_we, output logic after_wait);
        @(posedge clk); #1;
        mem_read_v[idx] = rd; mem_write_v[idx] = wr;
        read_adr = radr; write_adr = wadr; write_dat = wdat;
        @(negedge clk);
        first_we = we_v[idx]; first_adr = ram_adr_v[idx]; first_wdat = ram_wdat_v[idx];
        waits = 0;
        while (waiting_v[idx] && waits < 64) begin
            waits++;
            @(negedge clk);
        end
        done_rdat = rdat_v[idx];
        done_wait = waiting_v[idx];
        @(posedge clk); #1;
        mem_read_v[idx] = 1'b0; mem_write_v[idx] = 1'b0;
        @(negedge clk);
        after_we = we_v[idx];
        after_wait = waiting_v[idx];
    endtask

    task automatic run_check(input string tag, input int idx, input vec_t v);
        logic fwe, dw, awe, aw;
        logic [15:0] fadr, fwd, dr;
        int w;
        do_txn(idx, v.rd, v.wr, v.radr, v.wadr, v.wdat, fwe, fadr, fwd, w, dr, dw, awe, aw);
        $display("txn %s lat_inst=%0d rd=%0b wr=%0b radr=%h wadr=%h waits=%0d rdat=%h",
                 tag, idx, v.rd, v.wr, v.radr, v.wadr, w, dr);
        check({tag, " ram_we"}, 32'(fwe), 32'(v.exp_we));
        check({tag, " ram_adr"}, 32'(fadr), 32'(v.exp_adr));
        if (v.wr) check({tag, " ram_wdat"}, 32'(fwd), 32'(v.wdat));
        check({tag, " wait_cycles"}, 32'(w), 32'(v.exp_waits));
        check({tag, " done_waiting"}, 32'(dw), 32'd0);
        check({tag, " read_dat"}, 32'(dr), 32'(v.exp_rdat));
        check({tag, " after_we"}, 32'(awe), 32'd0);
        check({tag, " after_waiting"}, 32'(aw), 32'd0);
    endtask

    initial begin
        vec_t lv;
        for (int i = 0; i < 3; i++) begin
            mem_read_v[i] = 1'b0;
            mem_write_v[i] = 1'b0;
        end
        //         rd    wr    radr      wadr      wdat     we    adr       waits rdat
        vecs[0] = '{1'b0, 1'b0, 16'h0055, 16'h0000, 16'h0000, 1'b0, 16'h0055, 0, 16'h0000};
        vecs[1] = '{1'b0, 1'b1, 16'h0001, 16'h0010, 16'h1234, 1'b1, 16'h0010, 0, 16'h0000};
        vecs[2] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'h0000, 1'b0, 16'h0010, 3, 16'h1234};
        vecs[3] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 16'h0000, 1'b0, 16'h0020, 3, 16'hBEEF};
        vecs[4] = '{1'b1, 1'b1, 16'h0030, 16'h0030, 16'hA5A5, 1'b1, 16'h0030, 4, 16'hA5A5};
        vecs[5] = '{1'b1, 1'b1, 16'h0040, 16'h0050, 16'h7777, 1'b1, 16'h0050, 4, 16'h0F0F};
        vecs[6] = '{1'b0, 1'b0, 16'h0077, 16'h0000, 16'h0000, 1'b0, 16'h0077, 0, 16'h0F0F};
        vecs[7] = '{1'b0, 1'b1, 16'h0002, 16'h0020, 16'hCAFE, 1'b1, 16'h0020, 0, 16'h0F0F};

        // Preload while reset is held.
        preload(16'h0020, 16'hBEEF);
        preload(16'h0040, 16'h0F0F);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("reset waiting", 32'(waiting_v[0]), 32'd0);
        check("reset ram_we", 32'(we_v[0]), 32'd0);
        check("reset read_dat", 32'(rdat_v[0]), 32'd0);

        for (int i = 0; i < 8; i++) run_check($sformatf("vec%0d", i), 0, vecs[i]);

        // Reset asserted in the second WAIT cycle of a read.
        @(posedge clk); #1;
        mem_read_v[0] = 1'b1; read_adr = 16'h0020;
        @(negedge clk);
        check("midrst idle waiting", 32'(waiting_v[0]), 32'd1);
        @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        mem_write_v[0] = 1'b1; write_adr = 16'h0099; write_dat = 16'h1111;
        @(negedge clk);
        $display("txn midrst reset asserted in WAIT2");
        check("midrst waiting", 32'(waiting_v[0]), 32'd0);
        check("midrst ram_we", 32'(we_v[0]), 32'd0);
        check("midrst read_dat", 32'(rdat_v[0]), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        mem_read_v[0] = 1'b0; mem_write_v[0] = 1'b0;
        @(negedge clk);
        check("postrst waiting", 32'(waiting_v[0]), 32'd0);
        lv = '{1'b1, 1'b0, 16'h0040, 16'h0000, 16'h0000, 1'b0, 16'h0040, 3, 16'h0F0F};
        run_check("postrst_read", 0, lv);

        // Latency variants.
        lv = '{1'b1, 1'b0, 16'h0020, 16'h0000, 16'h0000, 1'b0, 16'h0020, 2, 16'hBEEF};
        run_check("lat1_read", 1, lv);
        lv = '{1'b1, 1'b0, 16'h0020, 16'h0000, 16'h0000, 1'b0, 16'h0020, 5, 16'hBEEF};
        run_check("lat4_read", 2, lv);
        lv = '{1'b1, 1'b1, 16'h0060, 16'h0060, 16'h2222, 1'b1, 16'h0060, 3, 16'h2222};
        run_check("lat1_both", 1, lv);
        lv = '{1'b1, 1'b1, 16'h0060, 16'h0060, 16'h4444, 1'b1, 16'h0060, 6, 16'h4444};
        run_check("lat4_both", 2, lv);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
